conv_config_serializer: RTL

// - Host-side producer for the conv controller's parameter FIFO.
// - The host loads 14 layer fields into shadow registers. On start, the block serializes them into
//   {config_adr, config_data} byte entries, addresses 0..NUM_CONFIGS-2.
// - It then emits the terminator entry at address NUM_CONFIGS-1, which moves the controller out of IDLE.

---
 rtl/conv_config_serializer_if.sv | 36 +++
 rtl/conv_config_serializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/conv_config_serializer_if.sv
// conv_config_serializer_if
//   Groups the host field-write port, the start/busy/done handshake and the
//   parameter-FIFO producer port of conv_config_serializer.
//   Signals:
//     cfg_wen, cfg_field[3:0], cfg_wdata   host shadow-register write port
//     start / busy / done                  transfer request and status
//     params_fifo_din, params_fifo_enq     FIFO entry {adr, data} and enqueue strobe
//     params_fifo_full_n                   FIFO has space
//   Modports:
//     master  host + FIFO side (drives writes, start and full_n)
//     slave   serializer side (drives status and the FIFO entry)
interface conv_config_serializer_if #(
    parameter int CONFIG_ADDR_WIDTH = 8,
    parameter int CONFIG_DATA_WIDTH = 8,
    parameter int FIELD_WIDTH       = 32
);
    logic                                         cfg_wen;
    logic [3:0]                                   cfg_field;
    logic [FIELD_WIDTH-1:0]                       cfg_wdata;
    logic                                         start;
    logic                                         busy;
    logic                                         done;
    logic [CONFIG_ADDR_WIDTH+CONFIG_DATA_WIDTH-1:0] params_fifo_din;
    logic                                         params_fifo_enq;
    logic                                         params_fifo_full_n;

    modport master (
        output cfg_wen, cfg_field, cfg_wdata, start, params_fifo_full_n,
        input  busy, done, params_fifo_din, params_fifo_enq
    );

    modport slave (
        input  cfg_wen, cfg_field, cfg_wdata, start, params_fifo_full_n,
        output busy, done, params_fifo_din, params_fifo_enq
    );
endinterface

// File: rtl/conv_config_serializer.sv
// conv_config_serializer
//   Host-side producer for the conv controller's parameter FIFO. The host
//   loads 14 layer fields into byte-wide shadow registers; a start pulse
//   serializes them as {adr, data} entries for addresses 0..33 and then
//   emits the terminator entry {34, 8'h00}.
//   Ports:
//     clk   clock
//     rst   asynchronous active-high reset
//     bus   conv_config_serializer_if.slave (field writes, start/busy/done,
//           params_fifo_din/enq/full_n)
//   Optional feature macro: CONV_CFG_SKIP_UNCHANGED_EN
//     When defined, a last-sent copy and per-byte dirty bits are kept and
//     only bytes that changed since they were last transferred are sent;
//     skipped bytes still take one cycle. The terminator is always sent.
module conv_config_serializer #(
    parameter int CONFIG_ADDR_WIDTH = 8,
    parameter int CONFIG_DATA_WIDTH = 8,
    parameter int NUM_CONFIGS       = 35,
    parameter int FIELD_WIDTH       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    conv_config_serializer_if.slave  bus
);

    localparam int NUM_BYTES = NUM_CONFIGS - 1;
    localparam int IDX_W     = $clog2(NUM_CONFIGS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_TERM
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           done_q, done_d;
    logic [CONFIG_DATA_WIDTH-1:0]   shadow_q [NUM_BYTES];
    logic [CONFIG_DATA_WIDTH-1:0]   shadow_d [NUM_BYTES];

`ifdef CONV_CFG_SKIP_UNCHANGED_EN
    logic [CONFIG_DATA_WIDTH-1:0]   last_q [NUM_BYTES];
    logic [CONFIG_DATA_WIDTH-1:0]   last_d [NUM_BYTES];
    logic [NUM_BYTES-1:0]           dirty_q, dirty_d;
`endif

    logic [FIELD_WIDTH-1:0]         wdata;
    logic [IDX_W-1:0]               wr_base;
    logic                           fld_valid;
    logic                           fld_wide;
    logic                           need_send;
    logic                           advance;
    logic                           enq;
    logic [CONFIG_ADDR_WIDTH+CONFIG_DATA_WIDTH-1:0] din;

    assign wdata = bus.cfg_wdata;

    // Byte address of the first byte of the addressed field: 16-bit fields
    // sit at 2k, 32-bit fields 11..13 sit at 22+4(k-11) = 4k-22.
    always_comb begin
        fld_valid = (bus.cfg_field < 4'd14);
        fld_wide  = (bus.cfg_field >= 4'd11);
        if (fld_wide) begin
            wr_base = IDX_W'({bus.cfg_field, 2'b00}) - IDX_W'(22);
        end else begin
            wr_base = IDX_W'({bus.cfg_field, 1'b0});
        end
    end

    // A byte is sent unless the skip feature finds it clean and unchanged.
    always_comb begin
`ifdef CONV_CFG_SKIP_UNCHANGED_EN
        need_send = dirty_q[idx_q] | (shadow_q[idx_q] != last_q[idx_q]);
`else
        need_send = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        shadow_d = shadow_q;
        enq     = 1'b0;
        din     = '0;
        advance = 1'b0;
`ifdef CONV_CFG_SKIP_UNCHANGED_EN
        last_d  = last_q;
        dirty_d = dirty_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Writes land on the same edge that captures start, so a
                // write paired with start is part of that transfer.
                if (bus.cfg_wen && fld_valid) begin
                    for (int n = 0; n < 4; n++) begin
                        if (n < 2 || fld_wide) begin
                            shadow_d[wr_base + IDX_W'(n)] = wdata[8*n +: 8];
                        end
                    end
                end
                if (bus.start) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                end
            end

            ST_SEND: begin
                din = {CONFIG_ADDR_WIDTH'(idx_q), shadow_q[idx_q]};
                if (need_send) begin
                    enq     = bus.params_fifo_full_n;
                    advance = bus.params_fifo_full_n;
`ifdef CONV_CFG_SKIP_UNCHANGED_EN
                    if (bus.params_fifo_full_n) begin
                        last_d[idx_q]  = shadow_q[idx_q];
                        dirty_d[idx_q] = 1'b0;
                    end
`endif
                end else begin
                    advance = 1'b1;
                end
                if (advance) begin
                    if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
                        state_d = ST_TERM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_TERM: begin
                din = {CONFIG_ADDR_WIDTH'(NUM_CONFIGS - 1), {CONFIG_DATA_WIDTH{1'b0}}};
                enq = bus.params_fifo_full_n;
                if (bus.params_fifo_full_n) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset returns to IDLE immediately, so the combinational enq drops
    // asynchronously and any partial stream is abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_BYTES; i++) begin
                shadow_q[i] <= '0;
            end
`ifdef CONV_CFG_SKIP_UNCHANGED_EN
            for (int i = 0; i < NUM_BYTES; i++) begin
                last_q[i] <= '0;
            end
            dirty_q <= '1;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
`ifdef CONV_CFG_SKIP_UNCHANGED_EN
            last_q   <= last_d;
            dirty_q  <= dirty_d;
`endif
        end
    end

    assign bus.busy            = (state_q != ST_IDLE);
    assign bus.done            = done_q;
    assign bus.params_fifo_din = din;
    assign bus.params_fifo_enq = enq;

endmodule
